div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//   Iterative signed divider; the inverse of the shift-add multiplier in the
//   datapath. It produces a truncated quotient and a remainder with the
//   dividend's sign, retiring one quotient bit per cycle (restoring algorithm).
//   It sits beside the multiplier and uses the same start/busy handshake.
// PARAMETERS
//   WIDTH  16  operand width; dividend, divisor, quotient and remainder are all WIDTH bits
// PORTS
//   clk_i        in   1      clock, rising edge
//   rst_n        in   1      reset, asynchronous, active-low
//   start_i      in   1      request; sampled only when busy_o=0
//   a_i          in   WIDTH  signed dividend
//   b_i          in   WIDTH  signed divisor
//   quotient_o   out  WIDTH  signed quotient, registered
//   remainder_o  out  WIDTH  signed remainder, registered
//   busy_o       out  1      operation in progress
//   done_o       out  1      single-cycle pulse when results update
//   div0_o       out  1      last op had divisor 0 (only with DIV_ZERO_EN; otherwise tied 0)
// BEHAVIOUR
//   Reset (async): quotient_o, remainder_o, busy_o, done_o, div0_o, all internal regs -> 0.
//   Accept: at edge E0 with start_i=1 and busy_o=0, latch the following:
//     |a|, |b| as WIDTH-bit unsigned magnitudes (-MIN handled as 2^(WIDTH-1))
//     qsign = a[MSB]^b[MSB]; rsign = a[MSB]
//     rem <= 0 (WIDTH+1 bits); quo <= |a|; count <= 0; busy_o <= 1
//   start_i while busy_o=1: ignored; latched operands are unaffected.
//   Iterate (each edge while busy):
//     trial = {rem[WIDTH-1:0], quo[MSB]} - {1'b0,|b|}
//     trial >= 0: rem <= trial, quo <= {quo[WIDTH-2:0],1}
//     else:       rem <= {rem[WIDTH-1:0],quo[MSB]}, quo <= {quo[WIDTH-2:0],0}
//     count <= count+1; count is $clog2(WIDTH+1) bits
//   Finish: on the edge where count==WIDTH-1, write the final-step results:
//     quotient_o  <= qsign ? -q : q
//     remainder_o <= rsign ? -r : r
//     busy_o <= 0; done_o <= 1 for exactly one cycle
//   Latency: results and done_o are valid WIDTH cycles after the accept edge.
//     busy_o is high for WIDTH cycles. Back-to-back: start_i may be accepted
//     in the cycle done_o is high.
//   Outputs hold their values until the next completion; they do not change
//     at accept.
//   Arithmetic: truncation toward zero; |r| < |b|; a = q*b + r.
//   Overflow: MIN / -1 -> quotient MIN (wraps), remainder 0; no flag.
//   Divisor 0, feature off: runs the full WIDTH cycles.
//     quotient = a[MSB] ? +1 : -1 (all ones), remainder = a.
//   Reset mid-operation: abort immediately, all state and outputs to 0;
//     no done_o pulse.
// CONFIGURATION
//   DIV_ZERO_EN defined: b_i==0 at accept is detected. Completion is on the
//     next edge (latency 1).
//     quotient_o <= all ones, remainder_o <= a_i, div0_o <= 1, done_o pulses.
//     Any non-zero-divisor completion clears div0_o.
//   DIV_ZERO_EN undefined: no detection logic; div0_o constant 0.
//     Divide-by-zero follows the feature-off rule above.
// TESTING
//   100/7 -> q=14, r=2, done_o exactly 16 cycles after accept, busy_o high 16 cycles
//   -100/7 -> q=-14, r=-2; 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2
//   -32768/-1 -> q=-32768 (0x8000), r=0; 7/100 -> q=0, r=7
//   5/0 feature off -> q=0xFFFF, r=5, 16 cycles; -5/0 -> q=1, r=-5; with DIV_ZERO_EN -> q=0xFFFF, r=5, div0_o=1, done_o 1 cycle after accept
//   start_i=1 with new operands on cycle 5 of a busy op -> ignored, original result delivered; back-to-back start on done cycle -> accepted
//   rst_n low at cycle 8 of an op -> all outputs 0 at once, no done_o; next op after release correct

Source files
------------

// File: rtl/div_seq.sv
// Iterative signed restoring divider: one quotient bit per cycle, truncating quotient,
// remainder takes the dividend's sign. Optional fast divide-by-zero path under DIV_ZERO_EN.
module div_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_bmag;
  logic             r_qsign;
  logic             r_rsign;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;

  logic [WIDTH-1:0] w_amag;
  logic [WIDTH-1:0] w_bmag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic             w_last;
  logic             w_unused;

  // Magnitudes; the most negative value maps to 2^(WIDTH-1) as an unsigned result.
  assign w_amag = a_i[WIDTH-1] ? (~a_i + WIDTH'(1)) : a_i;
  assign w_bmag = b_i[WIDTH-1] ? (~b_i + WIDTH'(1)) : b_i;

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  assign w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_bmag};
  assign w_ge      = ~w_diff[WIDTH+1];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH:0] : w_shift;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  assign w_q_fin = r_qsign ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;
  assign w_r_fin = r_rsign ? (~w_rem_nxt[WIDTH-1:0] + WIDTH'(1)) : w_rem_nxt[WIDTH-1:0];
  assign w_last  = (r_count == CW'(WIDTH - 1));

  // The partial remainder never exceeds WIDTH bits, so its top bit is never consumed.
  assign w_unused = r_rem[WIDTH];

`ifdef DIV_ZERO_EN
  logic r_zero;
  logic r_div0;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_bmag      <= '0;
      r_qsign     <= 1'b0;
      r_rsign     <= 1'b0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_zero      <= 1'b0;
      r_div0      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start_i) begin
          r_zero  <= (b_i == '0);
          // A zero divisor keeps the raw dividend so it can be returned as the remainder.
          r_quo   <= (b_i == '0) ? a_i : w_amag;
          r_bmag  <= w_bmag;
          r_qsign <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
          r_rsign <= a_i[WIDTH-1];
          r_rem   <= '0;
          r_count <= '0;
          r_state <= ST_BUSY;
        end
      end else if (r_zero) begin
        r_quotient  <= '1;
        r_remainder <= r_quo;
        r_div0      <= 1'b1;
        r_done      <= 1'b1;
        r_zero      <= 1'b0;
        r_state     <= ST_IDLE;
      end else begin
        r_rem   <= w_rem_nxt;
        r_quo   <= w_quo_nxt;
        r_count <= r_count + CW'(1);
        if (w_last) begin
          r_quotient  <= w_q_fin;
          r_remainder <= w_r_fin;
          r_div0      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end
      end
    end
  end

  assign div0_o = r_div0;
`else
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_bmag      <= '0;
      r_qsign     <= 1'b0;
      r_rsign     <= 1'b0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start_i) begin
          r_quo   <= w_amag;
          r_bmag  <= w_bmag;
          r_qsign <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
          r_rsign <= a_i[WIDTH-1];
          r_rem   <= '0;
          r_count <= '0;
          r_state <= ST_BUSY;
        end
      end else begin
        // A zero divisor simply runs the full loop: every trial succeeds.
        r_rem   <= w_rem_nxt;
        r_quo   <= w_quo_nxt;
        r_count <= r_count + CW'(1);
        if (w_last) begin
          r_quotient  <= w_q_fin;
          r_remainder <= w_r_fin;
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end
      end
    end
  end

  assign div0_o = 1'b0;
`endif

  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;
  assign busy_o      = (r_state == ST_BUSY);
  assign done_o      = r_done;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: signed quadrants, overflow, divide-by-zero, ignored and
// back-to-back starts, and asynchronous reset mid-operation.
module tb_div_seq;

  localparam int unsigned W = 16;

`ifdef DIV_ZERO_EN
  localparam int          ZLAT  = 1;
  localparam logic        ZDIV0 = 1'b1;
  localparam logic [W-1:0] ZNEG_Q = 16'hFFFF;
`else
  localparam int          ZLAT  = 16;
  localparam logic        ZDIV0 = 1'b0;
  localparam logic [W-1:0] ZNEG_Q = 16'h0001;
`endif

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         busy_o;
  logic         done_o;
  logic         div0_o;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .div0_o      (div0_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start an op at the next falling edge and follow it to done_o, checking everything.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input int elat, input logic ediv0);
    logic [W-1:0] q_prev;
    int n;
    int nb;
    @(negedge clk_i);
    q_prev  = quotient_o;
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check({tag, " busy_at_accept"}, 32'(busy_o), 32'd1);
    check({tag, " q_hold_at_accept"}, 32'(quotient_o), 32'(q_prev));
    n  = 0;
    nb = 1;
    while (!done_o && n < 40) begin
      @(posedge clk_i);
      #1;
      n++;
      if (busy_o) nb++;
    end
    check({tag, " latency"}, 32'(n), 32'(elat));
    check({tag, " busy_cycles"}, 32'(nb), 32'(elat));
    check({tag, " quotient"}, 32'(quotient_o), 32'(eq));
    check({tag, " remainder"}, 32'(remainder_o), 32'(er));
    check({tag, " div0"}, 32'(div0_o), 32'(ediv0));
  endtask

  initial begin
    int  n;
    logic seen;
    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    #23;
    check("reset quotient", 32'(quotient_o), 32'd0);
    check("reset remainder", 32'(remainder_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset div0", 32'(div0_o), 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;

    do_op("100/7",     16'd100,  16'd7,    16'h000E, 16'h0002, 16, 1'b0);
    do_op("-100/7",    16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 16, 1'b0);
    do_op("100/-7",    16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 16, 1'b0);
    do_op("-100/-7",   16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 16, 1'b0);
    do_op("MIN/-1",    16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 16, 1'b0);
    do_op("7/100",     16'd7,    16'd100,  16'h0000, 16'h0007, 16, 1'b0);
    do_op("MIN/7",     16'h8000, 16'd7,    16'hEDB7, 16'hFFFF, 16, 1'b0);
    do_op("MAX/MIN",   16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 16, 1'b0);
    do_op("5/0",       16'd5,    16'd0,    16'hFFFF, 16'h0005, ZLAT, ZDIV0);
    do_op("-5/0",      16'hFFFB, 16'd0,    ZNEG_Q,   16'hFFFB, ZLAT, ZDIV0);
    // Called while done_o is still high: the start must be taken on the done cycle.
    check("b2b done_high", 32'(done_o), 32'd1);
    do_op("b2b 100/7", 16'd100,  16'd7,    16'h000E, 16'h0002, 16, 1'b0);

    // New operands presented mid-operation must not disturb the running divide.
    @(negedge clk_i);
    start_i = 1'b1;
    a_i     = 16'd300;
    b_i     = 16'd9;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    n = 0;
    while (!done_o && n < 40) begin
      @(negedge clk_i);
      start_i = (n == 4);
      a_i     = 16'd1000;
      b_i     = 16'd3;
      @(posedge clk_i);
      #1;
      n++;
    end
    start_i = 1'b0;
    check("ignore latency", 32'(n), 32'd16);
    check("ignore quotient", 32'(quotient_o), 32'd33);
    check("ignore remainder", 32'(remainder_o), 32'd3);
    @(posedge clk_i);
    #1;
    check("ignore no_restart", 32'(busy_o), 32'd0);

    // Reset in the middle of an op clears everything at once and suppresses done_o.
    @(negedge clk_i);
    start_i = 1'b1;
    a_i     = 16'd1234;
    b_i     = 16'd5;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    check("midrst quotient", 32'(quotient_o), 32'd0);
    check("midrst remainder", 32'(remainder_o), 32'd0);
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o || busy_o) seen = 1'b1;
    end
    check("midrst no_done", 32'(seen), 32'd0);
    do_op("post-rst -100/-7", 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
